// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags,
// sticky overflow/underflow errors and a registered read port with valid strobe.
module param_sync_fifo #(
  parameter int unsigned WIDTH    = 9,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       err_clr
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             rd_accept;
  logic             wr_accept;
  logic             ovf_set;
  logic             unf_set;

  // Flags decode the count register directly so they track it with no added latency.
  assign count        = count_q;
  assign empty        = (count_q == '0);
  assign full         = (count_q == CW'(DEPTH));
  assign almost_full  = (count_q >= CW'(AF_LEVEL));
  assign almost_empty = (count_q <= CW'(AE_LEVEL));

  // A flush suppresses every transfer and error in its cycle.
  assign rd_accept = rd_en & ~empty & ~clr;
  assign wr_accept = wr_en & (~full | rd_accept) & ~clr;
  assign ovf_set   = wr_en & ~wr_accept & ~clr;
  assign unf_set   = rd_en & empty & ~clr;

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (clr) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count_q  <= '0;
        rd_valid <= 1'b0;
      end else begin
        if (wr_accept) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (rd_accept) begin
          rd_data  <= mem[rd_ptr];
          rd_ptr   <= rd_ptr + AW'(1);
          rd_valid <= 1'b1;
        end else begin
          rd_valid <= 1'b0;
        end
        case ({wr_accept, rd_accept})
          2'b10:   count_q <= count_q + CW'(1);
          2'b01:   count_q <= count_q - CW'(1);
          default: count_q <= count_q;
        endcase
      end
      // A new error in the same cycle as err_clr wins over the clear.
      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (err_clr) begin
        overflow <= 1'b0;
      end
      if (unf_set) begin
        underflow <= 1'b1;
      end else if (err_clr) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench for param_sync_fifo at default parameters (WIDTH=9, DEPTH=8,
// AF_LEVEL=6, AE_LEVEL=2): vector table plus hand-written corner sequences.
module tb_param_sync_fifo;

  logic       clk;
  logic       rst;
  logic       clr;
  logic       wr_en;
  logic [8:0] wr_data;
  logic       rd_en;
  logic [8:0] rd_data;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [3:0] count;
  logic       overflow;
  logic       underflow;
  logic       err_clr;

  int total;
  int bad;

  typedef struct {
    logic       wr;
    logic [8:0] wd;
    logic       rd;
    logic       cl;
    logic       ec;
    int         cnt;
    logic       rv;
    logic [8:0] rdd;
    logic       ovf;
    logic       unf;
  } vec_t;

  vec_t vecs[$];

  param_sync_fifo dut (
    .clk          (clk),
    .rst          (rst),
    .clr          (clr),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .err_clr      (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic vec_t mk(logic wr, int wd, logic rd, logic cl, logic ec,
                              int cnt, logic rv, int rdd, logic ovf, logic unf);
    vec_t v;
    v.wr = wr; v.wd = 9'(wd); v.rd = rd; v.cl = cl; v.ec = ec;
    v.cnt = cnt; v.rv = rv; v.rdd = 9'(rdd); v.ovf = ovf; v.unf = unf;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Flags follow from the expected count with AF_LEVEL=6 and AE_LEVEL=2.
  task automatic check_out(string tag, int cnt, logic rv, int rdd, logic ovf, logic unf);
    chk({tag, ".count"}, int'(count), cnt);
    chk({tag, ".full"}, int'(full), int'(cnt == 8));
    chk({tag, ".empty"}, int'(empty), int'(cnt == 0));
    chk({tag, ".almost_full"}, int'(almost_full), int'(cnt >= 6));
    chk({tag, ".almost_empty"}, int'(almost_empty), int'(cnt <= 2));
    chk({tag, ".rd_valid"}, int'(rd_valid), int'(rv));
    chk({tag, ".rd_data"}, int'(rd_data), rdd);
    chk({tag, ".overflow"}, int'(overflow), int'(ovf));
    chk({tag, ".underflow"}, int'(underflow), int'(unf));
  endtask

  task automatic step(logic wr, int wd, logic rd, logic cl, logic ec);
    wr_en = wr; wr_data = 9'(wd); rd_en = rd; clr = cl; err_clr = ec;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_data = '0; rd_en = 1'b0; clr = 1'b0; err_clr = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    idle_inputs();

    // Fill, overflow, drain, underflow, err_clr, empty-simultaneous.
    for (int k = 1; k <= 8; k++) vecs.push_back(mk(1, k, 0, 0, 0, k, 0, 0, 0, 0));
    vecs.push_back(mk(1, 'h1FF, 0, 0, 0, 8, 0, 0, 1, 0));
    for (int k = 1; k <= 8; k++) vecs.push_back(mk(0, 0, 1, 0, 0, 8 - k, 1, k, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 8, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 8, 0, 0));
    vecs.push_back(mk(1, 'hAA, 1, 0, 0, 1, 0, 8, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 'hAA, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 'hAA, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0, 'hAA, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 'hAA, 0, 0));

    repeat (3) @(posedge clk);
    #1;
    check_out("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].wr, int'(vecs[i].wd), vecs[i].rd, vecs[i].cl, vecs[i].ec);
      check_out($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].rv, int'(vecs[i].rdd),
                vecs[i].ovf, vecs[i].unf);
    end

    // Full with simultaneous write and read: both accepted, no overflow.
    for (int i = 0; i < 8; i++) begin
      step(1, 'h10 + i, 0, 0, 0);
      check_out("fill2", i + 1, 0, 'hAA, 0, 0);
    end
    step(1, 'h55, 1, 0, 0);
    check_out("full_rw", 8, 1, 'h10, 0, 0);
    for (int j = 0; j < 8; j++) begin
      step(0, 0, 1, 0, 0);
      check_out("drain2", 7 - j, 1, (j < 7) ? ('h11 + j) : 'h55, 0, 0);
    end

    // Streaming at occupancy 3 across several pointer wraps.
    for (int i = 0; i < 3; i++) begin
      step(1, 'h100 + i, 0, 0, 0);
      check_out("prime", i + 1, 0, 'h55, 0, 0);
    end
    for (int i = 3; i < 23; i++) begin
      step(1, 'h100 + i, 1, 0, 0);
      check_out("stream", 3, 1, 'h100 + i - 3, 0, 0);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0, 0);
      check_out("tail", 2 - i, 1, 'h114 + i, 0, 0);
    end

    // Flush at count 5 with a concurrent write: nothing stored.
    for (int i = 0; i < 5; i++) begin
      step(1, 'hC0 + i, 0, 0, 0);
      check_out("pre_clr", i + 1, 0, 'h116, 0, 0);
    end
    step(1, 'h1EE, 1, 1, 0);
    check_out("clr", 0, 0, 'h116, 0, 0);
    step(0, 0, 1, 0, 0);
    check_out("post_clr_rd", 0, 0, 'h116, 0, 1);
    step(1, 'hA1, 0, 0, 0);
    check_out("w1", 1, 0, 'h116, 0, 1);
    step(1, 'hA2, 0, 0, 0);
    check_out("w2", 2, 0, 'h116, 0, 1);
    step(0, 0, 1, 0, 0);
    check_out("r1", 1, 1, 'hA1, 0, 1);
    idle_inputs();

    // Asynchronous reset between clock edges.
    #2;
    rst = 1'b0;
    #1;
    check_out("async_rst", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    step(1, 'h33, 0, 0, 0);
    check_out("after_rst_w", 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    check_out("after_rst_r", 0, 1, 'h33, 0, 0);
    idle_inputs();
    step(0, 0, 0, 0, 0);
    check_out("final_idle", 0, 0, 'h33, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/param_sync_fifo.md
Name: param_sync_fifo

Overview:
Parametrised single-clock FIFO. It is the successor to the fixed 8x9 FIFO and is generalised in data width and depth. Compared with that block it adds occupancy count, full/empty and programmable almost-full/almost-empty flags, sticky overflow/underflow error flags, and a registered read port with a valid strobe. It sits between a producer and a consumer in the same clock domain, and replaces externally driven pointer increments with internal handshake-qualified pointers.

Parameters:
WIDTH, 9, data word width in bits (>=1)
DEPTH, 8, number of entries; power of two, >=2
AF_LEVEL, DEPTH-2, almost_full asserted when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 2, almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-low reset
clr  in  1  synchronous flush: pointers and count to zero
wr_en  in  1  write request
wr_data  in  WIDTH  write data
rd_en  in  1  read request
rd_data  out  WIDTH  registered read data
rd_valid  out  1  rd_data holds a word popped on the previous edge
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
count  out  $clog2(DEPTH+1)  current occupancy
overflow  out  1  sticky: write attempted while not accepted
underflow  out  1  sticky: read attempted while empty
err_clr  in  1  synchronous clear of overflow/underflow

Behaviour:
- Reset (rst=0, asynchronous assert, synchronous-safe deassert): wr/rd pointers=0, count=0, rd_data=0, rd_valid=0, overflow=0, underflow=0. Consequently empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0 ? n/a : 0). Storage array is not reset.
- Pointers are $clog2(DEPTH) bits and wrap DEPTH-1 -> 0 naturally. Count is held in a separate register.
- rd_accept = rd_en & ~empty.
- wr_accept = wr_en & (~full | rd_accept). A write to a full FIFO succeeds only when a read is accepted in the same cycle.
- No write-to-read bypass: when empty, a read is rejected even if wr_en=1 in the same cycle. The written word becomes readable on the next cycle.
- Write: on the edge with wr_accept, mem[wr_ptr] <= wr_data and wr_ptr += 1.
- Read: on the edge with rd_accept, rd_data <= mem[rd_ptr], rd_ptr += 1, rd_valid <= 1. Otherwise rd_valid <= 0 and rd_data holds its value. Read latency is 1 cycle.
- Count update:
  - +1 when wr_accept & ~rd_accept
  - -1 when rd_accept & ~wr_accept
  - unchanged when both or neither are accepted
  - never exceeds DEPTH and never goes below 0
- Flags full, empty, almost_full and almost_empty are combinational decodes of the count register. They update in the same cycle count changes, with no extra latency.
- overflow <= 1 on any edge with wr_en & ~wr_accept. underflow <= 1 on any edge with rd_en & empty. Both hold until err_clr or reset. If err_clr and a new error occur in the same cycle, the set wins.
- clr has priority over wr_en/rd_en in its cycle:
  - pointers and count go to 0 and rd_valid goes to 0; no write or read occurs.
  - rd_data is unchanged.
  - overflow/underflow are unaffected.
  - Requests during clr do not set error flags.
- Reset mid-operation: all state listed above returns to reset values immediately, independent of clk. Contents are discarded logically.

Test Plan:
- Reset then fill (defaults WIDTH=9, DEPTH=8): release rst, write 0x001..0x008 on consecutive cycles -> count steps 1..8; almost_full at count 6; full=1 after 8th write; empty=0 after 1st write.
- Drain with latency check: from full, hold rd_en 8 cycles -> rd_data 0x001..0x008 each one cycle after its request with rd_valid=1; empty=1 after last read; almost_empty at count 2; rd_valid=0 the cycle after rd_en drops.
- Boundary errors: write when full with rd_en=0 -> count stays 8, overflow=1, data unchanged; read when empty -> underflow=1, rd_valid=0; err_clr -> both flags 0.
- Simultaneous at boundaries:
  - Full with wr_en=rd_en=1 -> both accepted, count stays 8, no overflow.
  - Empty with wr_en=rd_en=1 -> read rejected, underflow=1, count becomes 1.
- Wrap-around: 20 cycles of continuous streaming with occupancy 3 (write/read every cycle, values 0x100+i) -> output sequence in order with no loss across pointer wrap; count constant at 3.
- clr and async reset: with count=5, assert clr with wr_en=1 -> count=0, empty=1, no write stored. Then write 2 words and pulse rst low between clock edges -> outputs go to reset values immediately.
